axilite_regbank: RTL and testbench
==================================

# axilite_regbank

Parametrised AXI4-Lite slave register bank. It is the successor to the fixed four-word config cell: N double-buffered configuration words, a control word and M read-only status words. Committed words drive a downstream datapath block; a one-cycle `param_en` marks every update. Committed words change only on an explicit or automatic commit, so a multi-word parameter set can be loaded atomically.

## Interface
- `NUM_REGS`, 4, number of RW config words (1..64)
- `NUM_STATUS`, 2, number of RO status words (0..64)
- `DATA_WIDTH`, 32, AXI data width (32 or 64)
- `ADDR_SIZE`, 32, AXI address width
- `AUTO_COMMIT_RST`, 1, reset value of control bit 1 (auto-commit)
- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `awaddr`/`awvalid`/`awready`  in/in/out  ADDR_SIZE/1/1  write address channel
- `wdata`/`wstrb`/`wvalid`/`wready`  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel
- `bresp`/`bvalid`/`bready`  out/out/in  2/1/1  write response
- `araddr`/`arvalid`/`arready`  in/in/out  ADDR_SIZE/1/1  read address channel
- `rdata`/`rresp`/`rvalid`/`rready`  out/out/out/in  DATA_WIDTH/2/1/1  read data channel
- `status_in`  in  NUM_STATUS*DATA_WIDTH  live status words (word k at bits k*DATA_WIDTH)
- `regs_out`  out  NUM_REGS*DATA_WIDTH  committed config words
- `param_en`  out  1  one-cycle pulse when `regs_out` changed

## Operation
- Word index = addr[ADDR_LSB +: IDXW], ADDR_LSB = log2(DATA_WIDTH/8). Upper address bits are ignored.
- Index map:
  - 0..NUM_REGS-1: shadow config (RW).
  - NUM_REGS: control. Bit0 is write-1 commit and self-clears; it reads as 0. Bit1 is auto-commit (RW).
  - NUM_REGS+1..NUM_REGS+NUM_STATUS: status (RO).
  - Any other index: unmapped.
- Writes:
  - AW and W are captured independently into holding registers.
  - The write executes in the first cycle both are held.
  - Byte lanes are merged under `wstrb`.
- Write responses:
  - Config or control write: OKAY.
  - Status write: SLVERR, no effect.
  - Unmapped write: DECERR, no effect.
- Commit copies all shadow words to `regs_out`. Two triggers:
  - Explicit: control write with bit0=1 and `wstrb[0]`=1. This write also applies the new bit1 value.
  - Auto: a config-word write while auto-commit=1. The commit uses the just-merged shadow value.
- Reads:
  - Config index returns the shadow value.
  - Control index returns {0, auto, 0}.
  - Status index returns `status_in` sampled at the AR handshake.
  - Unmapped index returns 0 with DECERR. All other reads return OKAY.
- One outstanding transaction per direction. Read and write channels are fully independent.

## Timing
- Reset values:
  - `awready`, `wready`, `arready` = 1.
  - `bvalid`, `rvalid`, `param_en` = 0; `bresp`, `rresp` = 0; `rdata` = 0.
  - Shadow and `regs_out` = 0; auto = AUTO_COMMIT_RST.
  - Reset mid-transaction drops held AW/W and any pending B/R with no response.
- `awready` = !aw_held && !bvalid. `wready` = !w_held && !bvalid.
- Write latency: if both channels handshake in cycle N, the registers update at the N edge and `bvalid` is high from N+1. If AW and W arrive in different cycles, `bvalid` rises the cycle after the later one.
- `bvalid` holds, with `bresp` stable, until `bready`. Ready is deasserted while `bvalid` is high.
- Commit triggered in cycle N: `regs_out` holds the new value and `param_en`=1 in cycle N+1 only. There is no pulse for SLVERR/DECERR writes or for non-commit control writes.
- `arready` = !rvalid. AR handshake in cycle N puts `rvalid` and `rdata` out in cycle N+1. Both hold until `rready`, and `rdata` stays stable even if `status_in` changes.
- A read of a shadow word in the same cycle as its write returns the old value.

## Structure
- Shared package `axilite_pkg`: RESP_OKAY=0, RESP_EXOKAY=1, RESP_SLVERR=2, RESP_DECERR=3, and a `idx_kind_t` enum (CFG, CTRL, STAT, UNMAPPED).
- One sub-module, `axilite_regbank_decode`: combinational index → kind/offset decoder, instanced once per channel.
- Top level: write holding FSM (IDLE, HAVE_AW, HAVE_W, RESP), read FSM (IDLE, RESP), shadow/commit storage.

## Test plan
- Reset, auto=1. Write idx1 = 0xDEADBEEF with strb 0xF → `bresp`=OKAY; `regs_out` word1 = 0xDEADBEEF and `param_en`=1 for exactly one cycle, both the cycle after the write.
- Write control = 0x0, then idx0 = 0x11, then idx2 = 0x22 → `regs_out` unchanged, no pulse. Write control = 0x1 → words 0 and 2 update together, single `param_en` pulse. Reading control returns 0x0.
- Strobe merge: idx3 = 0xAABBCCDD, then 0x11223344 with strb 0b0101 → read idx3 returns 0xAA22CC44.
- W three cycles before AW; hold `bready`=0 for 4 cycles → `awready`/`wready` low while `bvalid` high; `bresp` stable; exactly one write.
- Write status idx → SLVERR, no change. Read idx NUM_REGS+1 with `status_in` word0 = 0x5A5A, changed during stalled `rready` → `rdata`=0x5A5A OKAY. Read idx 63 → 0 with DECERR.
- Assert `rst` while AW held and W pending → all outputs at reset values the next cycle. A following normal write completes OKAY.

Source files
------------

// File: rtl/axilite_pkg.sv
// ============================================================================
//  Module      : axilite_pkg
//  Description : Shared AXI4-Lite response codes and register-index kinds.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axilite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  // Region a word index falls into.
  typedef enum logic [1:0] {
    CFG      = 2'd0,
    CTRL     = 2'd1,
    STAT     = 2'd2,
    UNMAPPED = 2'd3
  } idx_kind_t;

  // Index width: enough to cover config words, the control word and status words.
  function automatic int idx_width(input int num_regs, input int num_status);
    return $clog2(num_regs + num_status + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/axilite_regbank_decode.sv
// ============================================================================
//  Module      : axilite_regbank_decode
//  Description : Combinational word-index decoder. Classifies an index as
//                config / control / status / unmapped and returns the offset
//                of the word inside its region.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axilite_regbank_decode
  import axilite_pkg::*;
#(
  parameter int NUM_REGS   = 4,
  parameter int NUM_STATUS = 2,
  parameter int IDXW       = 3
) (
  input  logic [IDXW-1:0] idx,
  output idx_kind_t       kind,
  output logic [IDXW-1:0] offset
);

  // Region lookup: config words first, then control, then status.
  always_comb begin
    kind   = UNMAPPED;
    offset = '0;
    if (32'(idx) < NUM_REGS) begin
      kind   = CFG;
      offset = idx;
    end else if (32'(idx) == NUM_REGS) begin
      kind = CTRL;
    end else if (32'(idx) <= NUM_REGS + NUM_STATUS) begin
      kind   = STAT;
      offset = idx - IDXW'(NUM_REGS + 1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/axilite_regbank.sv
// ============================================================================
//  Module      : axilite_regbank
//  Description : AXI4-Lite slave register bank with double-buffered config
//                words, a control word (commit / auto-commit) and read-only
//                status words. Committed words appear on regs_out together
//                with a one-cycle param_en pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axilite_regbank
  import axilite_pkg::*;
#(
  parameter int NUM_REGS        = 4,
  parameter int NUM_STATUS      = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_SIZE       = 32,
  parameter bit AUTO_COMMIT_RST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_SIZE-1:0]      awaddr,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ADDR_SIZE-1:0]      araddr,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready,
  input  logic [(NUM_STATUS > 0 ? NUM_STATUS : 1)*DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic                      param_en
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDXW     = idx_width(NUM_REGS, NUM_STATUS);

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_t;

  wr_state_t r_wst, w_wst_next;
  rd_state_t r_rst_st, w_rst_next;

  logic [ADDR_SIZE-1:0]  r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic [1:0]            r_bresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  r_auto;
  logic                  r_param_en;
  logic [DATA_WIDTH-1:0] r_shadow [NUM_REGS];
  logic [DATA_WIDTH-1:0] r_regs   [NUM_REGS];

  logic                  w_aw_hs, w_w_hs, w_ar_hs;
  logic                  w_have_aw, w_have_w, w_do_write;
  logic [ADDR_SIZE-1:0]  w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  idx_kind_t             w_wkind, w_rkind;
  logic [IDXW-1:0]       w_woff, w_roff;
  logic [DATA_WIDTH-1:0] w_shadow_next [NUM_REGS];
  logic                  w_commit;
  logic [1:0]            w_bresp;
  logic [DATA_WIDTH-1:0] w_rval;
  logic [1:0]            w_rresp;
  logic                  w_unused;

  // Handshakes and ready/valid outputs follow directly from the FSM states.
  assign awready = (r_wst == W_IDLE) || (r_wst == W_HAVE_W);
  assign wready  = (r_wst == W_IDLE) || (r_wst == W_HAVE_AW);
  assign bvalid  = (r_wst == W_RESP);
  assign bresp   = r_bresp;
  assign arready = (r_rst_st == R_IDLE);
  assign rvalid  = (r_rst_st == R_RESP);
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign param_en = r_param_en;

  assign w_aw_hs = awvalid && awready;
  assign w_w_hs  = wvalid && wready;
  assign w_ar_hs = arvalid && arready;

  // A channel counts as present if it is held or handshaking right now, so a
  // write whose second half arrives this cycle executes at this edge.
  assign w_have_aw  = (r_wst == W_HAVE_AW) || w_aw_hs;
  assign w_have_w   = (r_wst == W_HAVE_W) || w_w_hs;
  assign w_do_write = w_have_aw && w_have_w;
  assign w_addr     = (r_wst == W_HAVE_AW) ? r_awaddr : awaddr;
  assign w_data     = (r_wst == W_HAVE_W) ? r_wdata : wdata;
  assign w_strb     = (r_wst == W_HAVE_W) ? r_wstrb : wstrb;

  axilite_regbank_decode #(
    .NUM_REGS   (NUM_REGS),
    .NUM_STATUS (NUM_STATUS),
    .IDXW       (IDXW)
  ) u_wdec (
    .idx    (w_addr[ADDR_LSB +: IDXW]),
    .kind   (w_wkind),
    .offset (w_woff)
  );

  axilite_regbank_decode #(
    .NUM_REGS   (NUM_REGS),
    .NUM_STATUS (NUM_STATUS),
    .IDXW       (IDXW)
  ) u_rdec (
    .idx    (araddr[ADDR_LSB +: IDXW]),
    .kind   (w_rkind),
    .offset (w_roff)
  );

  // Write FSM next state: collect AW and W in either order, then respond.
  always_comb begin
    w_wst_next = r_wst;
    case (r_wst)
      W_IDLE: begin
        if (w_do_write)   w_wst_next = W_RESP;
        else if (w_aw_hs) w_wst_next = W_HAVE_AW;
        else if (w_w_hs)  w_wst_next = W_HAVE_W;
      end
      W_HAVE_AW: if (w_w_hs)  w_wst_next = W_RESP;
      W_HAVE_W:  if (w_aw_hs) w_wst_next = W_RESP;
      W_RESP:    if (bready)  w_wst_next = W_IDLE;
      default:   w_wst_next = W_IDLE;
    endcase
  end

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_wst <= W_IDLE;
    else     r_wst <= w_wst_next;
  end

  // Shadow words after this cycle's write, with byte lanes merged under strobe.
  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      w_shadow_next[k] = r_shadow[k];
      if (w_do_write && (w_wkind == CFG) && (w_woff == IDXW'(k))) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (w_strb[b]) w_shadow_next[k][b*8 +: 8] = w_data[b*8 +: 8];
        end
      end
    end
  end

  // Commit on explicit control bit0, or on any config write while auto is set.
  assign w_commit = w_do_write &&
                    (((w_wkind == CFG) && r_auto) ||
                     ((w_wkind == CTRL) && w_strb[0] && w_data[0]));

  assign w_bresp = (w_wkind == CFG || w_wkind == CTRL) ? RESP_OKAY :
                   (w_wkind == STAT) ? RESP_SLVERR : RESP_DECERR;

  // Write-side storage: holding registers, shadow, control, committed words.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bresp    <= RESP_OKAY;
      r_auto     <= AUTO_COMMIT_RST;
      r_param_en <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
        r_shadow[k] <= '0;
        r_regs[k]   <= '0;
      end
    end else begin
      if (w_aw_hs) r_awaddr <= awaddr;
      if (w_w_hs) begin
        r_wdata <= wdata;
        r_wstrb <= wstrb;
      end
      if (w_do_write) r_bresp <= w_bresp;
      if (w_do_write && (w_wkind == CTRL) && w_strb[0]) r_auto <= w_data[1];
      r_param_en <= w_commit;
      for (int k = 0; k < NUM_REGS; k++) begin
        r_shadow[k] <= w_shadow_next[k];
        if (w_commit) r_regs[k] <= w_shadow_next[k];
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
      assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
    end
  endgenerate

  // Read data mux; shadow is read before any same-cycle write lands.
  always_comb begin
    w_rval  = '0;
    w_rresp = RESP_OKAY;
    case (w_rkind)
      CFG: begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (w_roff == IDXW'(k)) w_rval = r_shadow[k];
        end
      end
      CTRL: w_rval[1] = r_auto;
      STAT: begin
        for (int k = 0; k < NUM_STATUS; k++) begin
          if (w_roff == IDXW'(k)) w_rval = status_in[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      default: w_rresp = RESP_DECERR;
    endcase
  end

  // Read FSM next state: accept one address, hold data until rready.
  always_comb begin
    w_rst_next = r_rst_st;
    case (r_rst_st)
      R_IDLE:  if (w_ar_hs) w_rst_next = R_RESP;
      R_RESP:  if (rready)  w_rst_next = R_IDLE;
      default: w_rst_next = R_IDLE;
    endcase
  end

  // Read FSM state register and read data capture at the AR handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rst_st <= R_IDLE;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else begin
      r_rst_st <= w_rst_next;
      if (w_ar_hs) begin
        r_rdata <= w_rval;
        r_rresp <= w_rresp;
      end
    end
  end

  // Address bits above the index field are intentionally ignored.
  assign w_unused = ^{awaddr, araddr, r_awaddr, status_in};

endmodule

`default_nettype wire

// File: tb/tb_axilite_regbank.sv
// ============================================================================
//  Module      : tb_axilite_regbank
//  Description : Self-checking bench for axilite_regbank with a transaction
//                level model of the register map and per-cycle comparison.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axilite_regbank;
  import axilite_pkg::*;

  localparam int NR = 4;
  localparam int NS = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] awaddr, araddr;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready, param_en;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [NS*DW-1:0] status_in;
  logic [NR*DW-1:0] regs_out;

  always #5 clk = ~clk;

  axilite_regbank #(
    .NUM_REGS(NR), .NUM_STATUS(NS), .DATA_WIDTH(DW), .ADDR_SIZE(AW), .AUTO_COMMIT_RST(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .status_in(status_in), .regs_out(regs_out), .param_en(param_en)
  );

  int errors = 0;
  int checks = 0;

  // Model of the register map.
  logic [DW-1:0] m_shadow [NR];
  logic [DW-1:0] m_regs [NR];
  bit m_auto;
  bit exp_pe;
  logic [1:0]    exp_bq[$];
  logic [DW-1:0] exp_rdq[$];
  logic [1:0]    exp_rrq[$];
  bit pend_aw, pend_w;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_data;
  logic [SW-1:0] pend_strb;

  bit run_chk = 0;
  int pe_count = 0;
  int n_bhs = 0;
  bit last_aw_hs, last_w_hs, last_ar_hs, last_b_hs, last_r_hs;
  logic [1:0] last_bresp, last_rresp;
  logic [DW-1:0] last_rdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NR; k++) begin
      m_shadow[k] = '0;
      m_regs[k] = '0;
    end
    m_auto = 1'b1;
    exp_pe = 1'b0;
    exp_bq.delete();
    exp_rdq.delete();
    exp_rrq.delete();
    pend_aw = 0;
    pend_w = 0;
  endtask

  task automatic model_commit();
    for (int k = 0; k < NR; k++) m_regs[k] = m_shadow[k];
    exp_pe = 1'b1;
  endtask

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    int idx;
    idx = int'(a >> 2);
    if (idx < NR) begin
      for (int b = 0; b < SW; b++)
        if (s[b]) m_shadow[idx][b*8 +: 8] = d[b*8 +: 8];
      if (m_auto) model_commit();
      exp_bq.push_back(RESP_OKAY);
    end else if (idx == NR) begin
      if (s[0]) begin
        m_auto = d[1];
        if (d[0]) model_commit();
      end
      exp_bq.push_back(RESP_OKAY);
    end else if (idx <= NR + NS) begin
      exp_bq.push_back(RESP_SLVERR);
    end else begin
      exp_bq.push_back(RESP_DECERR);
    end
  endtask

  task automatic model_read(input logic [AW-1:0] a, input logic [NS*DW-1:0] st);
    int idx;
    idx = int'(a >> 2);
    if (idx < NR) begin
      exp_rdq.push_back(m_shadow[idx]); exp_rrq.push_back(RESP_OKAY);
    end else if (idx == NR) begin
      exp_rdq.push_back(DW'(m_auto) << 1); exp_rrq.push_back(RESP_OKAY);
    end else if (idx <= NR + NS) begin
      exp_rdq.push_back(st[(idx-NR-1)*DW +: DW]); exp_rrq.push_back(RESP_OKAY);
    end else begin
      exp_rdq.push_back('0); exp_rrq.push_back(RESP_DECERR);
    end
  endtask

  // One clock: observe handshakes before the edge, update the model after it.
  task automatic tick();
    logic [AW-1:0] aa, ra;
    logic [DW-1:0] dd;
    logic [SW-1:0] ss;
    logic [NS*DW-1:0] st;
    @(negedge clk);
    last_aw_hs = awvalid && awready;
    last_w_hs  = wvalid && wready;
    last_ar_hs = arvalid && arready;
    last_b_hs  = bvalid && bready;
    last_r_hs  = rvalid && rready;
    aa = awaddr; dd = wdata; ss = wstrb; ra = araddr; st = status_in;
    if (last_b_hs) last_bresp = bresp;
    if (last_r_hs) begin
      last_rdata = rdata;
      last_rresp = rresp;
    end
    @(posedge clk);
    #1;
    exp_pe = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    if (last_b_hs) begin
      n_bhs++;
      if (exp_bq.size() != 0) void'(exp_bq.pop_front());
    end
    if (last_r_hs && exp_rdq.size() != 0) begin
      void'(exp_rdq.pop_front());
      void'(exp_rrq.pop_front());
    end
    if (last_ar_hs) model_read(ra, st);
    if (last_aw_hs) begin pend_aw = 1; pend_addr = aa; end
    if (last_w_hs)  begin pend_w = 1; pend_data = dd; pend_strb = ss; end
    if (pend_aw && pend_w) begin
      model_write(pend_addr, pend_data, pend_strb);
      pend_aw = 0;
      pend_w = 0;
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (run_chk) begin
      if (param_en) pe_count++;
      for (int k = 0; k < NR; k++) check("regs_out", regs_out[k*DW +: DW], m_regs[k]);
      check("param_en", param_en, exp_pe);
      check("bvalid", bvalid, exp_bq.size() != 0);
      check("rvalid", rvalid, exp_rdq.size() != 0);
      if (bvalid) begin
        check("ready_low_while_bvalid", {awready, wready}, 2'b00);
        if (exp_bq.size() != 0) check("bresp", bresp, exp_bq[0]);
      end
      if (rvalid) begin
        check("arready_low_while_rvalid", arready, 1'b0);
        if (exp_rdq.size() != 0) begin
          check("rdata", rdata, exp_rdq[0]);
          check("rresp", rresp, exp_rrq[0]);
        end
      end
    end
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                          input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, b_done = 0;
    int c = 0, bw = 0;
    awaddr = a; wdata = d; wstrb = s;
    while (!b_done && c < 200) begin
      awvalid = !aw_done && (c >= aw_dly);
      wvalid  = !w_done && (c >= w_dly);
      bready  = aw_done && w_done && (bw >= b_dly);
      tick();
      if (last_aw_hs) aw_done = 1;
      if (last_w_hs) w_done = 1;
      if (last_b_hs) b_done = 1;
      if (aw_done && w_done) bw++;
      c++;
    end
    awvalid = 0; wvalid = 0; bready = 0;
    resp = last_bresp;
    if (!b_done) begin
      checks++; errors++;
      $display("FAIL write_timeout: got no response expected bvalid for addr %h", a);
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int r_dly, input bit chg, input logic [DW-1:0] nst,
                         output logic [DW-1:0] d, output logic [1:0] resp);
    bit ar_done = 0, r_done = 0;
    int c = 0, rw = 0;
    araddr = a;
    while (!r_done && c < 200) begin
      arvalid = !ar_done;
      rready  = ar_done && (rw >= r_dly);
      tick();
      if (last_ar_hs) begin
        ar_done = 1;
        if (chg) status_in[DW-1:0] = nst;
      end
      if (last_r_hs) r_done = 1;
      if (ar_done) rw++;
      c++;
    end
    arvalid = 0; rready = 0;
    d = last_rdata; resp = last_rresp;
    if (!r_done) begin
      checks++; errors++;
      $display("FAIL read_timeout: got no data expected rvalid for addr %h", a);
    end
  endtask

  initial begin
    logic [1:0] br, rr;
    logic [DW-1:0] rd;
    int pe0, nb0;

    rst = 1; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    status_in = {32'h0000_C3C3, 32'h0000_5A5A};
    tick(); tick();
    rst = 0;
    run_chk = 1;
    check("reset_awready", awready, 1'b1);
    check("reset_wready", wready, 1'b1);
    check("reset_arready", arready, 1'b1);
    check("reset_regs_out", regs_out, '0);
    check("reset_rdata", rdata, '0);

    // Auto-commit write.
    do_write(32'h4, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, br);
    check("t1_bresp", br, RESP_OKAY);
    check("t1_word1", regs_out[1*DW +: DW], 32'hDEAD_BEEF);
    check("t1_pulses", pe_count, 1);

    // Disable auto, stage two words, then explicit commit.
    do_write(32'h10, 32'h0, 4'hF, 0, 0, 0, br);
    do_write(32'h0, 32'h11, 4'hF, 0, 0, 0, br);
    do_write(32'h8, 32'h22, 4'hF, 0, 0, 0, br);
    check("t2_no_pulse", pe_count, 1);
    check("t2_word0_unchanged", regs_out[0 +: DW], 32'h0);
    do_write(32'h10, 32'h1, 4'hF, 0, 0, 0, br);
    check("t2_single_pulse", pe_count, 2);
    check("t2_word0", regs_out[0 +: DW], 32'h11);
    check("t2_word2", regs_out[2*DW +: DW], 32'h22);
    do_read(32'h10, 0, 0, '0, rd, rr);
    check("t2_ctrl_read", rd, 32'h0);

    // Strobe merge.
    do_write(32'hC, 32'hAABB_CCDD, 4'hF, 0, 0, 0, br);
    do_write(32'hC, 32'h1122_3344, 4'b0101, 0, 0, 0, br);
    do_read(32'hC, 0, 0, '0, rd, rr);
    check("t3_merge", rd, 32'hAA22_CC44);

    // W three cycles ahead of AW, response stalled.
    nb0 = n_bhs;
    do_write(32'h0, 32'h77, 4'hF, 3, 0, 5, br);
    check("t4_bresp", br, RESP_OKAY);
    check("t4_one_write", n_bhs, nb0 + 1);

    // Error responses and status read.
    pe0 = pe_count;
    do_write(32'h14, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, br);
    check("t5_status_slverr", br, RESP_SLVERR);
    do_write(32'h1C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, br);
    check("t5_unmapped_decerr", br, RESP_DECERR);
    check("t5_no_pulse", pe_count, pe0);
    do_read(32'hFC, 0, 0, '0, rd, rr);
    check("t5_idx63_data", rd, 32'h0);
    check("t5_idx63_resp", rr, RESP_DECERR);
    do_read(32'h14, 4, 1, 32'h0000_1234, rd, rr);
    check("t5_status_data", rd, 32'h0000_5A5A);
    check("t5_status_resp", rr, RESP_OKAY);

    // Reset with AW held and W arriving.
    awaddr = 32'h8; awvalid = 1; wdata = 32'h55; wstrb = 4'hF;
    tick();
    awvalid = 0; wvalid = 1; rst = 1;
    tick();
    rst = 0; wvalid = 0;
    check("rst_awready", awready, 1'b1);
    check("rst_wready", wready, 1'b1);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_bresp", bresp, RESP_OKAY);
    check("rst_rdata", rdata, '0);
    check("rst_param_en", param_en, 1'b0);
    check("rst_regs_out", regs_out, '0);
    pe0 = pe_count;
    do_write(32'h4, 32'h99, 4'hF, 0, 0, 0, br);
    check("post_rst_bresp", br, RESP_OKAY);
    check("post_rst_word1", regs_out[1*DW +: DW], 32'h99);
    check("post_rst_pulse", pe_count, pe0 + 1);
    do_read(32'h10, 0, 0, '0, rd, rr);
    check("post_rst_ctrl", rd, 32'h2);

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
